fwd_scoreboard_unit: RTL and testbench

//  Parametrised operand-forwarding and hazard unit for the EX pipeline.

---
 rtl/fwd_pkg.sv | 23 ++
 rtl/fwd_scoreboard_unit_if.sv | 46 ++++
 rtl/fwd_match_prio.sv | 35 +++
 rtl/fwd_scoreboard_unit.sv | 103 ++++++++++
 tb/tb_fwd_scoreboard_unit.sv | 369 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fwd_pkg.sv
// Shared types and helpers for the operand-forwarding scoreboard.
// Entries carry a fixed-width dst field; narrower register addresses are zero-extended into it.
package fwd_pkg;

  localparam int FWD_MAX_ADDR_W = 8;
  localparam int FWD_CNT_W      = 3;
  localparam int FWD_SEL_RF     = 0;

  typedef struct packed {
    logic                      valid;
    logic [FWD_MAX_ADDR_W-1:0] dst;
    logic [FWD_CNT_W-1:0]      cnt;
  } fwd_entry_t;

  function automatic int sel_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic logic [FWD_CNT_W-1:0] cnt_dec(input logic [FWD_CNT_W-1:0] c);
    return (c == '0) ? c : c - FWD_CNT_W'(1);
  endfunction

endpackage

// File: rtl/fwd_scoreboard_unit_if.sv
// Issue-side bundle between the EX issue stage (master) and the forwarding unit (slave).
// FWD_SCOREBOARD_STATS_EN adds the stall_cycles / fwd_events counter outputs.
interface fwd_scoreboard_unit_if
  import fwd_pkg::*;
#(
  parameter int NUM_SRC = 2,
  parameter int DEPTH   = 3,
  parameter int ADDR_W  = 5
) ();

  localparam int SEL_W = sel_w(DEPTH);

  logic                      issue_valid;
  logic                      issue_regwrite;
  logic                      issue_is_load;
  logic [ADDR_W-1:0]         issue_dst;
  logic                      flush;
  logic [NUM_SRC*ADDR_W-1:0] src_addr;
  logic [NUM_SRC*SEL_W-1:0]  fwd_sel;
  logic                      stall;
`ifdef FWD_SCOREBOARD_STATS_EN
  logic [31:0]               stall_cycles;
  logic [31:0]               fwd_events;

  modport master (
    output issue_valid, issue_regwrite, issue_is_load, issue_dst, flush, src_addr,
    input  fwd_sel, stall, stall_cycles, fwd_events
  );

  modport slave (
    input  issue_valid, issue_regwrite, issue_is_load, issue_dst, flush, src_addr,
    output fwd_sel, stall, stall_cycles, fwd_events
  );
`else
  modport master (
    output issue_valid, issue_regwrite, issue_is_load, issue_dst, flush, src_addr,
    input  fwd_sel, stall
  );

  modport slave (
    input  issue_valid, issue_regwrite, issue_is_load, issue_dst, flush, src_addr,
    output fwd_sel, stall
  );
`endif

endinterface

// File: rtl/fwd_match_prio.sv
// One source operand against all tracked producers; the youngest (lowest index) match wins.
// Purely combinational: hit/ready/idx follow src and the entry state in the same cycle.
module fwd_match_prio
  import fwd_pkg::*;
#(
  parameter int DEPTH  = 3,
  parameter int ADDR_W = 5,
  parameter int SEL_W  = 2
) (
  input  logic [ADDR_W-1:0]     src,
  input  fwd_entry_t [DEPTH-1:0] ents,
  output logic                  hit,
  output logic                  ready,
  output logic [SEL_W-1:0]      idx
);

  logic [FWD_MAX_ADDR_W-1:0] src_ext;

  assign src_ext = FWD_MAX_ADDR_W'(src);

  // Scan oldest to youngest so the last assignment is the youngest match.
  always_comb begin
    hit   = 1'b0;
    ready = 1'b0;
    idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ents[i].valid && (src != '0) && (ents[i].dst == src_ext)) begin
        hit   = 1'b1;
        ready = (ents[i].cnt == '0);
        idx   = SEL_W'(i);
      end
    end
  end

endmodule

// File: rtl/fwd_scoreboard_unit.sv
// Forwarding/hazard unit: fwd_sel and stall are combinational from state and src_addr; stall holds issue.
// FWD_SCOREBOARD_STATS_EN adds saturating stall_cycles / fwd_events counters.
module fwd_scoreboard_unit
  import fwd_pkg::*;
#(
  parameter int NUM_SRC  = 2,
  parameter int DEPTH    = 3,
  parameter int ADDR_W   = 5,
  parameter int LOAD_LAT = 1
) (
  input  logic                  Clk,
  input  logic                  Rst,
  fwd_scoreboard_unit_if.slave  bus
);

  localparam int SEL_W = sel_w(DEPTH);

  fwd_entry_t [DEPTH-1:0]          ents;
  fwd_entry_t                      new_ent;
  logic [NUM_SRC-1:0]              src_hit;
  logic [NUM_SRC-1:0]              src_ready;
  logic [NUM_SRC-1:0][SEL_W-1:0]   src_idx;
  logic [NUM_SRC*SEL_W-1:0]        fwd_sel_int;
  logic                            stall_int;

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    fwd_match_prio #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .SEL_W  (SEL_W)
    ) u_match (
      .src   (bus.src_addr[s*ADDR_W +: ADDR_W]),
      .ents  (ents),
      .hit   (src_hit[s]),
      .ready (src_ready[s]),
      .idx   (src_idx[s])
    );
  end

  always_comb begin
    fwd_sel_int = {NUM_SRC{SEL_W'(FWD_SEL_RF)}};
    for (int s = 0; s < NUM_SRC; s++) begin
      if (src_hit[s] && src_ready[s]) begin
        fwd_sel_int[s*SEL_W +: SEL_W] = src_idx[s] + SEL_W'(1);
      end
    end
  end

  // A flush squashes the consumer too, so there is nothing left to hold.
  assign stall_int   = bus.issue_valid & ~bus.flush & |(src_hit & ~src_ready);
  assign bus.stall   = stall_int;
  assign bus.fwd_sel = fwd_sel_int;

  always_comb begin
    new_ent       = '0;
    new_ent.valid = bus.issue_valid & bus.issue_regwrite & ~stall_int & (bus.issue_dst != '0);
    new_ent.dst   = FWD_MAX_ADDR_W'(bus.issue_dst);
    new_ent.cnt   = bus.issue_is_load ? FWD_CNT_W'(LOAD_LAT) : '0;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      ents <= '0;
    end else if (bus.flush) begin
      ents <= '0;
    end else begin
      ents[0] <= new_ent;
      for (int i = 1; i < DEPTH; i++) begin
        ents[i]     <= ents[i-1];
        ents[i].cnt <= cnt_dec(ents[i-1].cnt);
      end
    end
  end

`ifdef FWD_SCOREBOARD_STATS_EN
  logic [31:0] stall_cycles_q;
  logic [31:0] fwd_events_q;
  logic [32:0] fwd_sum;

  always_comb begin
    fwd_sum = {1'b0, fwd_events_q};
    for (int s = 0; s < NUM_SRC; s++) begin
      fwd_sum = fwd_sum + 33'(src_hit[s] & src_ready[s]);
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      stall_cycles_q <= '0;
      fwd_events_q   <= '0;
    end else begin
      if (stall_int && (stall_cycles_q != '1)) begin
        stall_cycles_q <= stall_cycles_q + 32'd1;
      end
      fwd_events_q <= fwd_sum[32] ? '1 : fwd_sum[31:0];
    end
  end

  assign bus.stall_cycles = stall_cycles_q;
  assign bus.fwd_events   = fwd_events_q;
`endif

endmodule

// File: tb/tb_fwd_scoreboard_unit.sv
// Scoreboard bench for fwd_scoreboard_unit: directed scenarios plus a randomized run against a reference model.
module tb_fwd_scoreboard_unit;
  import fwd_pkg::*;

  localparam int NUM_SRC  = 2;
  localparam int DEPTH    = 3;
  localparam int ADDR_W   = 5;
  localparam int LOAD_LAT = 1;
  localparam int SEL_W    = sel_w(DEPTH);

  typedef struct packed {
    logic [SEL_W-1:0] sel1;
    logic [SEL_W-1:0] sel0;
    logic             stall;
  } exp_t;

  typedef struct {
    bit iv, rw, ld;
    int dst, s0, s1;
    bit fl;
    int e0, e1;
    bit est;
  } row_t;

  typedef struct {
    bit vld;
    int dst;
    bit ld;
  } hist_t;

  logic  Clk = 1'b0;
  logic  Rst;
  int    n_pass  = 0;
  int    n_total = 0;
  exp_t  exp_q[$];
  hist_t hist[DEPTH];

  always #5 Clk = ~Clk;

  fwd_scoreboard_unit_if #(.NUM_SRC(NUM_SRC), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) bus ();

  fwd_scoreboard_unit #(
    .NUM_SRC  (NUM_SRC),
    .DEPTH    (DEPTH),
    .ADDR_W   (ADDR_W),
    .LOAD_LAT (LOAD_LAT)
  ) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  task automatic drive(input bit iv, input bit rw, input bit ld, input int dst,
                       input int s0, input int s1, input bit fl);
    bus.issue_valid    = iv;
    bus.issue_regwrite = rw;
    bus.issue_is_load  = ld;
    bus.issue_dst      = ADDR_W'(dst);
    bus.src_addr       = {ADDR_W'(s1), ADDR_W'(s0)};
    bus.flush          = fl;
  endtask

  task automatic next_edge();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle(input int n);
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (n) next_edge();
  endtask

  function automatic exp_t mk(input int s0, input int s1, input bit st);
    exp_t e;
    e.sel0  = SEL_W'(s0);
    e.sel1  = SEL_W'(s1);
    e.stall = st;
    return e;
  endfunction

  function automatic row_t row(input bit iv, input bit rw, input bit ld, input int dst,
                               input int s0, input int s1, input bit fl,
                               input int e0, input int e1, input bit est);
    row_t r;
    r.iv = iv; r.rw = rw; r.ld = ld; r.dst = dst; r.s0 = s0; r.s1 = s1; r.fl = fl;
    r.e0 = e0; r.e1 = e1; r.est = est;
    return r;
  endfunction

  // Reference: a producer at age index i has waited i edges, so a load is ready once i >= LOAD_LAT.
  function automatic exp_t model_eval(input int s0, input int s1, input bit iv, input bit fl);
    exp_t e;
    int   src[2];
    bit   st;
    e = '0;
    st = 1'b0;
    src[0] = s0;
    src[1] = s1;
    for (int s = 0; s < 2; s++) begin
      bit found;
      found = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        if (!found && hist[i].vld && hist[i].dst == src[s] && src[s] != 0) begin
          found = 1'b1;
          if (!hist[i].ld || i >= LOAD_LAT) begin
            if (s == 0) e.sel0 = SEL_W'(i + 1);
            else        e.sel1 = SEL_W'(i + 1);
          end else begin
            st = 1'b1;
          end
        end
      end
    end
    e.stall = st & iv & ~fl;
    return e;
  endfunction

  task automatic test_reset();
    exp_t e, got;
    for (int i = 0; i < 7; i++) begin
      if (i == 4) Rst = 1'b0;
      drive(1, 1, $urandom_range(0, 1), $urandom_range(0, 31), $urandom_range(0, 31),
            $urandom_range(0, 31), (i < 4) ? 1'($urandom_range(0, 1)) : 1'b0);
      if (i >= 4) bus.issue_valid = 1'b0;
      exp_q.push_back(mk(0, 0, 0));
      @(negedge Clk);
      got = {bus.fwd_sel, bus.stall};
      e = exp_q.pop_front();
      n_total++;
      if (got !== e) $display("FAIL reset cyc%0d: got sel1=%0d sel0=%0d stall=%0b, want sel1=%0d sel0=%0d stall=%0b",
                              i, got.sel1, got.sel0, got.stall, e.sel1, e.sel0, e.stall);
      else n_pass++;
      next_edge();
    end
  endtask

  task automatic test_alu_fwd();
    row_t rows[$];
    exp_t e, got;
    idle(DEPTH + 1);
    rows.push_back(row(1, 1, 0, 8, 0, 0, 0, 0, 0, 0));
    rows.push_back(row(1, 0, 0, 0, 8, 0, 0, 1, 0, 0));
    rows.push_back(row(0, 0, 0, 0, 8, 0, 0, 2, 0, 0));
    rows.push_back(row(0, 0, 0, 0, 8, 0, 0, 3, 0, 0));
    rows.push_back(row(0, 0, 0, 0, 8, 0, 0, 0, 0, 0));
    foreach (rows[i]) begin
      drive(rows[i].iv, rows[i].rw, rows[i].ld, rows[i].dst, rows[i].s0, rows[i].s1, rows[i].fl);
      exp_q.push_back(mk(rows[i].e0, rows[i].e1, rows[i].est));
      @(negedge Clk);
      got = {bus.fwd_sel, bus.stall};
      e = exp_q.pop_front();
      n_total++;
      if (got !== e) $display("FAIL alu_fwd row%0d: got sel1=%0d sel0=%0d stall=%0b, want sel1=%0d sel0=%0d stall=%0b",
                              i, got.sel1, got.sel0, got.stall, e.sel1, e.sel0, e.stall);
      else n_pass++;
      next_edge();
    end
  endtask

  task automatic test_load_use();
    row_t rows[$];
    exp_t e, got;
    idle(DEPTH + 1);
    rows.push_back(row(1, 1, 1, 9, 0, 0, 0, 0, 0, 0));
    rows.push_back(row(1, 0, 0, 0, 0, 9, 0, 0, 0, 1));
    rows.push_back(row(1, 0, 0, 0, 0, 9, 0, 0, 2, 0));
    rows.push_back(row(0, 0, 0, 0, 0, 9, 0, 0, 3, 0));
    rows.push_back(row(1, 1, 1, 9, 0, 0, 0, 0, 0, 0));
    rows.push_back(row(0, 0, 0, 0, 0, 9, 0, 0, 0, 0));
    rows.push_back(row(1, 0, 0, 0, 9, 9, 0, 2, 2, 0));
    foreach (rows[i]) begin
      drive(rows[i].iv, rows[i].rw, rows[i].ld, rows[i].dst, rows[i].s0, rows[i].s1, rows[i].fl);
      exp_q.push_back(mk(rows[i].e0, rows[i].e1, rows[i].est));
      @(negedge Clk);
      got = {bus.fwd_sel, bus.stall};
      e = exp_q.pop_front();
      n_total++;
      if (got !== e) $display("FAIL load_use row%0d: got sel1=%0d sel0=%0d stall=%0b, want sel1=%0d sel0=%0d stall=%0b",
                              i, got.sel1, got.sel0, got.stall, e.sel1, e.sel0, e.stall);
      else n_pass++;
      next_edge();
    end
  endtask

  task automatic test_back_to_back();
    row_t rows[$];
    exp_t e, got;
    idle(DEPTH + 1);
    rows.push_back(row(1, 1, 0, 4, 0, 0, 0, 0, 0, 0));
    rows.push_back(row(1, 1, 0, 4, 0, 0, 0, 0, 0, 0));
    rows.push_back(row(1, 1, 0, 6, 4, 4, 0, 1, 1, 0));
    rows.push_back(row(0, 0, 0, 0, 6, 4, 0, 1, 2, 0));
    rows.push_back(row(0, 0, 0, 0, 4, 6, 0, 3, 2, 0));
    foreach (rows[i]) begin
      drive(rows[i].iv, rows[i].rw, rows[i].ld, rows[i].dst, rows[i].s0, rows[i].s1, rows[i].fl);
      exp_q.push_back(mk(rows[i].e0, rows[i].e1, rows[i].est));
      @(negedge Clk);
      got = {bus.fwd_sel, bus.stall};
      e = exp_q.pop_front();
      n_total++;
      if (got !== e) $display("FAIL back_to_back row%0d: got sel1=%0d sel0=%0d stall=%0b, want sel1=%0d sel0=%0d stall=%0b",
                              i, got.sel1, got.sel0, got.stall, e.sel1, e.sel0, e.stall);
      else n_pass++;
      next_edge();
    end
  endtask

  task automatic test_reg_zero();
    row_t rows[$];
    exp_t e, got;
    idle(DEPTH + 1);
    rows.push_back(row(1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    rows.push_back(row(1, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    rows.push_back(row(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rows.push_back(row(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    foreach (rows[i]) begin
      drive(rows[i].iv, rows[i].rw, rows[i].ld, rows[i].dst, rows[i].s0, rows[i].s1, rows[i].fl);
      exp_q.push_back(mk(rows[i].e0, rows[i].e1, rows[i].est));
      @(negedge Clk);
      got = {bus.fwd_sel, bus.stall};
      e = exp_q.pop_front();
      n_total++;
      if (got !== e) $display("FAIL reg_zero row%0d: got sel1=%0d sel0=%0d stall=%0b, want sel1=%0d sel0=%0d stall=%0b",
                              i, got.sel1, got.sel0, got.stall, e.sel1, e.sel0, e.stall);
      else n_pass++;
      next_edge();
    end
  endtask

  task automatic test_flush();
    exp_t e, got;
    idle(DEPTH + 1);
    drive(1, 1, 1, 9, 0, 0, 0);
    next_edge();
    for (int k = 0; k < 3; k++) begin
      case (k)
        0: begin
          drive(1, 1, 0, 10, 9, 0, 0);
          exp_q.push_back(mk(0, 0, 1));
          @(negedge Clk);
        end
        1: begin
          bus.flush = 1'b1;
          exp_q.push_back(mk(0, 0, 0));
          #1;
        end
        default: begin
          next_edge();
          drive(1, 0, 0, 0, 9, 10, 0);
          exp_q.push_back(mk(0, 0, 0));
          @(negedge Clk);
        end
      endcase
      got = {bus.fwd_sel, bus.stall};
      e = exp_q.pop_front();
      n_total++;
      if (got !== e) $display("FAIL flush step%0d: got sel1=%0d sel0=%0d stall=%0b, want sel1=%0d sel0=%0d stall=%0b",
                              k, got.sel1, got.sel0, got.stall, e.sel1, e.sel0, e.stall);
      else n_pass++;
    end
    next_edge();
  endtask

  task automatic test_rst_mid_stall();
    exp_t e, got;
    idle(DEPTH + 1);
    drive(1, 1, 1, 9, 0, 0, 0);
    next_edge();
    for (int k = 0; k < 5; k++) begin
      case (k)
        0: begin
          drive(1, 0, 0, 0, 9, 0, 0);
          exp_q.push_back(mk(0, 0, 1));
          @(negedge Clk);
        end
        1: begin
          Rst = 1'b1;
          exp_q.push_back(mk(0, 0, 0));
          #1;
        end
        2: begin
          #1 Rst = 1'b0;
          next_edge();
          drive(1, 1, 0, 7, 9, 0, 0);
          exp_q.push_back(mk(0, 0, 0));
          @(negedge Clk);
        end
        3: begin
          next_edge();
          drive(0, 0, 0, 0, 7, 9, 0);
          exp_q.push_back(mk(1, 0, 0));
          @(negedge Clk);
        end
        default: begin
          next_edge();
          drive(0, 0, 0, 0, 9, 7, 0);
          exp_q.push_back(mk(0, 2, 0));
          @(negedge Clk);
        end
      endcase
      got = {bus.fwd_sel, bus.stall};
      e = exp_q.pop_front();
      n_total++;
      if (got !== e) $display("FAIL rst_mid_stall step%0d: got sel1=%0d sel0=%0d stall=%0b, want sel1=%0d sel0=%0d stall=%0b",
                              k, got.sel1, got.sel0, got.stall, e.sel1, e.sel0, e.stall);
      else n_pass++;
    end
    next_edge();
  endtask

  task automatic test_random();
    exp_t e, got;
    bit   iv, rw, ld, fl;
    int   dst, s0, s1;
    drive(0, 0, 0, 0, 0, 0, 0);
    Rst = 1'b1;
    #1 Rst = 1'b0;
    foreach (hist[i]) hist[i] = '{vld: 1'b0, dst: 0, ld: 1'b0};
    for (int n = 0; n < 300; n++) begin
      iv  = 1'($urandom_range(0, 1));
      rw  = 1'($urandom_range(0, 1));
      ld  = 1'($urandom_range(0, 1));
      fl  = ($urandom_range(0, 15) == 0);
      dst = $urandom_range(0, 3);
      s0  = $urandom_range(0, 3);
      s1  = $urandom_range(0, 3);
      drive(iv, rw, ld, dst, s0, s1, fl);
      e = model_eval(s0, s1, iv, fl);
      exp_q.push_back(e);
      if (fl) begin
        foreach (hist[i]) hist[i].vld = 1'b0;
      end else begin
        for (int i = DEPTH - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = '{vld: iv && rw && !e.stall && dst != 0, dst: dst, ld: ld};
      end
      @(negedge Clk);
      got = {bus.fwd_sel, bus.stall};
      e = exp_q.pop_front();
      n_total++;
      if (got !== e) $display("FAIL random cyc%0d: got sel1=%0d sel0=%0d stall=%0b, want sel1=%0d sel0=%0d stall=%0b",
                              n, got.sel1, got.sel0, got.stall, e.sel1, e.sel0, e.stall);
      else n_pass++;
      next_edge();
    end
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0);
    Rst = 1'b0;
    #1 Rst = 1'b1;
    test_reset();
    test_alu_fwd();
    test_load_use();
    test_back_to_back();
    test_reg_zero();
    test_flush();
    test_rst_mid_stall();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, got %0d/%0d checks", n_pass, n_total);
    $fatal(1);
  end

endmodule
